// File: rtl/rx_fifo_burst_arbiter_pkg.sv
// Shared types and constants for the two-channel RX FIFO burst arbiter.
package rx_fifo_burst_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  localparam logic CH_09 = 1'b0;  // sub-GHz channel
  localparam logic CH_24 = 1'b1;  // 2.4 GHz channel

  function automatic logic other_ch(input logic ch);
    return ~ch;
  endfunction

endpackage

// File: rtl/rx_fifo_burst_arbiter_rr_arb2.sv
// Two-requester grant cell: round-robin by default, fixed channel-0 priority
// when RX_ARB_STRICT_PRIORITY_EN is defined.
module rr_arb2
  import rx_fifo_burst_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       valid
);

`ifdef RX_ARB_STRICT_PRIORITY_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    valid = |req;
    grant = req[0] ? CH_09 : CH_24;
  end
`else
  always_comb begin
    valid = |req;
    grant = CH_09;
    if (req == 2'b11)
      grant = other_ch(last_grant);
    else if (req[1])
      grant = CH_24;
  end
`endif

endmodule

// File: rtl/rx_fifo_burst_arbiter.sv
// Read-side burst scheduler sharing one valid/ready stream between two RX FIFOs.
// Define RX_ARB_STRICT_PRIORITY_EN for fixed channel-0 priority instead of round-robin.
module rx_fifo_burst_arbiter
  import rx_fifo_burst_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [1:0]            ch_en_i,
  input  logic                  ch0_empty_i,
  input  logic                  ch1_empty_i,
  output logic                  ch0_rd_en_o,
  output logic                  ch1_rd_en_o,
  input  logic [DATA_WIDTH-1:0] ch0_data_i,
  input  logic [DATA_WIDTH-1:0] ch1_data_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_ch_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  out_last_o,
  output logic                  busy_o
);

  localparam int CW = $clog2(BURST_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST_LEN - 1);

  arb_state_e    state_reg, state_next;
  logic          sel_reg, sel_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          last_grant_reg, last_grant_next;
  logic          valid_reg, valid_next;
  logic          last_reg, last_next;

  logic [1:0] req;
  logic       arb_grant, arb_valid;
  logic       sel_empty, sel_en, slot_free, issue;

  assign req       = ch_en_i & {~ch1_empty_i, ~ch0_empty_i};
  assign sel_empty = sel_reg ? ch1_empty_i : ch0_empty_i;
  assign sel_en    = ch_en_i[sel_reg];
  assign slot_free = ~valid_reg | out_ready_i;
  // Gated by reset so no FIFO word is popped and then thrown away in the reset cycle.
  assign issue     = (state_reg == BURST) & slot_free & ~sel_empty & sel_en & ~rst_i;

  rr_arb2 u_arb (
    .req        (req),
    .last_grant (last_grant_reg),
    .grant      (arb_grant),
    .valid      (arb_valid)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      sel_reg        <= CH_09;
      cnt_reg        <= '0;
      last_grant_reg <= CH_24;
      valid_reg      <= 1'b0;
      last_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sel_reg        <= sel_next;
      cnt_reg        <= cnt_next;
      last_grant_reg <= last_grant_next;
      valid_reg      <= valid_next;
      last_reg       <= last_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    sel_next        = sel_reg;
    cnt_next        = cnt_reg;
    last_grant_next = last_grant_reg;
    valid_next      = valid_reg;
    last_next       = last_reg;
    case (state_reg)
      IDLE: begin
        if (arb_valid) begin
          sel_next   = arb_grant;
          cnt_next   = '0;
          state_next = BURST;
        end
      end
      BURST: begin
        if (issue) begin
          valid_next = 1'b1;
          last_next  = (cnt_reg == CNT_LAST);
          // The counter stops at its final value rather than wrapping.
          if (cnt_reg == CNT_LAST)
            state_next = DRAIN;
          else
            cnt_next = cnt_reg + CW'(1);
        end else begin
          if (out_ready_i) begin
            valid_next = 1'b0;
            last_next  = 1'b0;
          end
          if (slot_free && (sel_empty || !sel_en))
            state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!valid_reg || out_ready_i) begin
          valid_next      = 1'b0;
          last_next       = 1'b0;
          last_grant_next = sel_reg;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign ch0_rd_en_o = issue & (sel_reg == CH_09);
  assign ch1_rd_en_o = issue & (sel_reg == CH_24);
  assign out_data_o  = sel_reg ? ch1_data_i : ch0_data_i;
  assign out_ch_o    = sel_reg;
  assign out_valid_o = valid_reg;
  assign out_last_o  = last_reg;
  assign busy_o      = (state_reg != IDLE);

endmodule

// File: tb/tb_rx_fifo_burst_arbiter.sv
// Directed bench for rx_fifo_burst_arbiter with two behavioural FIFOs, BURST_LEN = 4.
module tb_rx_fifo_burst_arbiter;

  localparam int DW = 32;
  localparam int BL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, ready, flush;
  logic [1:0]    ch_en;
  logic          empty0, empty1, rd_en0, rd_en1;
  logic [DW-1:0] data0, data1, out_data;
  logic          out_ch, out_valid, out_last, busy;

  rx_fifo_burst_arbiter #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .ch_en_i     (ch_en),
    .ch0_empty_i (empty0),
    .ch1_empty_i (empty1),
    .ch0_rd_en_o (rd_en0),
    .ch1_rd_en_o (rd_en1),
    .ch0_data_i  (data0),
    .ch1_data_i  (data1),
    .out_data_o  (out_data),
    .out_ch_o    (out_ch),
    .out_valid_o (out_valid),
    .out_ready_i (ready),
    .out_last_o  (out_last),
    .busy_o      (busy)
  );

  // Behavioural FIFOs: word value encodes channel tag and write position.
  logic [DW-1:0] mem0 [0:255];
  logic [DW-1:0] mem1 [0:255];
  int wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;
  assign empty0 = (rd0 == wr0);
  assign empty1 = (rd1 == wr1);

  always @(posedge clk) begin
    if (flush) begin
      rd0 <= wr0;
      rd1 <= wr1;
    end else begin
      if (rd_en0) begin data0 <= mem0[rd0]; rd0 <= rd0 + 1; end
      if (rd_en1) begin data1 <= mem1[rd1]; rd1 <= rd1 + 1; end
    end
  end

  // Handshake monitor
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] q_data[$];
  logic          q_ch[$];
  logic          q_last[$];
  int            q_cyc[$];
  int            rd_empty_viol = 0;

  always @(negedge clk) begin
    if (!rst && out_valid && ready) begin
      q_data.push_back(out_data);
      q_ch.push_back(out_ch);
      q_last.push_back(out_last);
      q_cyc.push_back(cyc);
    end
    if ((rd_en0 && empty0) || (rd_en1 && empty1))
      rd_empty_viol <= rd_empty_viol + 1;
  end

  int n_checks = 0;
  int n_pass = 0;
  int mark = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] word(input int ch, input int ptr);
    return (ch != 0) ? (32'hB000_0000 | ptr) : (32'hA000_0000 | ptr);
  endfunction

  task automatic push(input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      if (ch == 0) begin mem0[wr0] = word(0, wr0); wr0++; end
      else         begin mem1[wr1] = word(1, wr1); wr1++; end
    end
  endtask

  task automatic wait_words(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && (q_data.size() - mark) < n; i++) begin
      @(negedge clk); #1;
    end
    check(tag, q_data.size() - mark, n);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; flush = 1'b1; ch_en = 2'b00; ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    mark = q_data.size();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  int s0, s1, b, ch, idx;

  initial begin
    rst = 1'b1; flush = 1'b1; ch_en = 2'b00; ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_rd_en", {rd_en1, rd_en0}, 2'b00);
    @(posedge clk); #1;
    flush = 1'b0; rst = 1'b0;
    mark = q_data.size();

    // 10 words on ch0 only: bursts of 4+4+2
    s0 = wr0;
    push(0, 10);
    ch_en = 2'b11;
    wait_words("t1_count", 10, 200);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t1_data%0d", i), q_data[mark+i], word(0, s0 + i));
      check($sformatf("t1_ch%0d", i), q_ch[mark+i], 0);
      check($sformatf("t1_last%0d", i), q_last[mark+i], (i == 3 || i == 7));
      if (i > 0)
        check($sformatf("t1_gap%0d", i), q_cyc[mark+i] - q_cyc[mark+i-1],
              (i == 4 || i == 8) ? 3 : 1);
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("t1_idle_busy", busy, 0);
    check("t1_fifo_left", wr0 - rd0, 0);

    // Both channels hold 8 words
    do_reset();
    s0 = wr0; s1 = wr1;
    push(0, 8); push(1, 8);
    ch_en = 2'b11;
    wait_words("t2_count", 16, 300);
    for (int k = 0; k < 16; k++) begin
`ifdef RX_ARB_STRICT_PRIORITY_EN
      ch = (k >= 8) ? 1 : 0;
      idx = k % 8;
`else
      b = k / 4;
      ch = b % 2;
      idx = (b / 2) * 4 + k % 4;
`endif
      check($sformatf("t2_ch%0d", k), q_ch[mark+k], ch);
      check($sformatf("t2_data%0d", k), q_data[mark+k], word(ch, (ch != 0 ? s1 : s0) + idx));
    end

    // Downstream stall for 5 cycles mid-burst
    do_reset();
    s0 = wr0;
    push(0, 6);
    ch_en = 2'b01;
    wait_words("t3_pre", 2, 50);
    @(posedge clk); #1;
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("t3_valid%0d", i), out_valid, 1);
      check($sformatf("t3_data%0d", i), out_data, word(0, s0 + 2));
      check($sformatf("t3_rd%0d", i), {rd_en1, rd_en0}, 2'b00);
    end
    @(posedge clk); #1;
    ready = 1'b1;
    wait_words("t3_count", 6, 100);
    for (int i = 0; i < 6; i++)
      check($sformatf("t3_word%0d", i), q_data[mark+i], word(0, s0 + i));

    // ch0 disabled mid-burst
    do_reset();
    s0 = wr0; s1 = wr1;
    push(0, 6); push(1, 3);
    ch_en = 2'b11;
    wait_words("t4_pre", 2, 50);
    @(posedge clk); #1;
    ch_en = 2'b10;
    wait_words("t4_count", 6, 100);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t4_ch0_%0d", i), {q_ch[mark+i], q_data[mark+i]}, {1'b0, word(0, s0 + i)});
      check($sformatf("t4_ch1_%0d", i), {q_ch[mark+3+i], q_data[mark+3+i]}, {1'b1, word(1, s1 + i)});
    end
    check("t4_ch0_retained", wr0 - rd0, 3);

    // Reset mid-burst
    do_reset();
    s0 = wr0; s1 = wr1;
    push(0, 6); push(1, 2);
    ch_en = 2'b01;
    wait_words("t5_pre", 2, 50);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_rd", {rd_en1, rd_en0}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0; ch_en = 2'b11;
    mark = q_data.size();
    @(negedge clk);
    check("t5_valid", out_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_rd", {rd_en1, rd_en0}, 2'b00);
    check("t5_rd_ptr", rd0 - s0, 3);
    wait_words("t5_count", 5, 100);
    check("t5_first", {q_ch[mark], q_data[mark]}, {1'b0, word(0, s0 + 3)});
    check("t5_ch1", {q_ch[mark+3], q_data[mark+3]}, {1'b1, word(1, s1)});

    check("rd_on_empty", rd_empty_viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
